mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; legal values 8..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in register stages; legal values 1..4.
REQ-003 SHALL have parameter TAG_W, default 5, width of the destination tag carried with each operation.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port stall, input, 1; hold every pipeline register.
REQ-007 SHALL have port flush, input, 1; kill all in-flight operations.
REQ-008 SHALL have port in_valid, input, 1; operation presented this cycle.
REQ-009 SHALL have port op, input, 2; 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 SHALL have ports opA and opB, input, WIDTH each; operands.
REQ-011 SHALL have port in_tag, input, TAG_W; destination register tag.
REQ-012 SHALL have port out_valid, output, 1; result present.
REQ-013 SHALL have port out_result, output, WIDTH; result.
REQ-014 SHALL have port out_tag, output, TAG_W; tag of the result.
REQ-015 SHALL have port busy, output, 1; OR of all stage valid bits.

Function
REQ-016 SHALL accept an operation at a rising edge when in_valid=1, stall=0 and flush=0; fully pipelined, one accept per cycle.
REQ-017 SHALL assert out_valid with result and tag in the cycle after the STAGES-th non-stalled edge following acceptance (latency STAGES).
REQ-018 SHALL, while stall=1 and flush=0, hold every stage's valid bit, data and tag unchanged, including out_valid/out_result/out_tag; in_valid is ignored.
REQ-019 SHALL, when flush=1, clear every valid bit at that edge regardless of stall; a simultaneous in_valid is dropped.
REQ-020 SHALL deliver results strictly in acceptance order; each accepted op produces out_valid for exactly one non-stalled cycle.
REQ-021 SHALL compute the full 2*WIDTH product with operands sign- or zero-extended per op: MUL uses low WIDTH bits; MULH signed×signed, MULHSU signed opA × unsigned opB, MULHU unsigned×unsigned, each returning high WIDTH bits.
REQ-022 SHALL leave out_result/out_tag holding their last registered value when out_valid=0; consumers qualify them with out_valid.
REQ-023 SHALL be timing-equivalent to STAGES registers after a combinational multiply; internal retiming or partial-product splitting is permitted.

Reset
REQ-024 SHALL, on a clock edge with rst_n=0, clear all valid bits, out_result and out_tag to 0, overriding stall and flush and aborting any in-flight op.
REQ-025 SHALL drive busy=0 and out_valid=0 in the first cycle after reset.

Configuration
REQ-026 SHALL compile MULH/MULHSU/MULHU support only when macro MUL_HIGH_EN is defined.
REQ-027 SHALL, without MUL_HIGH_EN, ignore op and always return the low WIDTH bits of the product; ports are unchanged.

Verification (WIDTH=32, STAGES=2, TAG_W=5)
REQ-028 SHALL verify: MUL 7 × 0xFFFFFFFD, tag 9 -> two edges later out_valid=1, out_result=0xFFFFFFEB, out_tag=9, for one cycle.
REQ-029 SHALL verify (MUL_HIGH_EN): MULH 0x80000000² -> 0x40000000; MULHU 0xFFFFFFFF² -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 SHALL verify: three back-to-back ops with stall=1 for 2 cycles after the second -> three in-order results, each out_valid exactly once, outputs frozen during stall.
REQ-031 SHALL verify: two ops in flight, then flush=1 together with stall=1 and in_valid=1 -> busy=0 and out_valid=0 for the next 3 cycles.
REQ-032 SHALL verify: rst_n=0 for one edge with one op in flight -> out_valid=0, out_result=0, out_tag=0, busy=0 afterwards.
REQ-033 SHALL verify (no MUL_HIGH_EN): op=11 with 0xFFFFFFFF² -> out_result=0x00000001.

Source files
------------

// File: rtl/mul_unit.sv
// Pipelined integer multiplier with destination tag, stall, flush and in-order results.
// Define MUL_HIGH_EN to add MULH/MULHSU/MULHU; without it every op returns the low product half.
module mul_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [WIDTH-1:0] res_c;

`ifdef MUL_HIGH_EN
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic          a_signed;
    logic          b_signed;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;

    // Extend both operands to 2*WIDTH so one unsigned multiply covers every signedness mix
    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU);
        b_signed = (op == OP_MULH);
        a_ext    = {{WIDTH{a_signed & opA[WIDTH-1]}}, opA};
        b_ext    = {{WIDTH{b_signed & opB[WIDTH-1]}}, opB};
        prod     = a_ext * b_ext;
        res_c    = (op == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    end
`else
    logic unused_op;

    // Low half only; op has no effect in this build
    assign res_c     = opA * opB;
    assign unused_op = ^op;
`endif

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    // Result shift pipeline; payload only advances behind a valid so idle outputs hold their last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= res_c;
                tag_q[0]  <= in_tag;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                end
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_result = data_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign busy       = |vld_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit (WIDTH=32, STAGES=2, TAG_W=5).
// Expected values depend on whether MUL_HIGH_EN is defined for the build.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul_unit #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .op         (op),
        .opA        (opA),
        .opB        (opB),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        in_valid = v;
        op       = o;
        opA      = a;
        opB      = b;
        in_tag   = t;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] r,
                              input logic [4:0] t);
        check({name, ".valid"}, 64'(out_valid), 64'(v));
        check({name, ".result"}, 64'(out_result), 64'(r));
        check({name, ".tag"}, 64'(out_tag), 64'(t));
    endtask

    // Single isolated op: result appears after the second edge for exactly one cycle
    task automatic run_one(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
        drive(1'b1, o, a, b, t);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        check({name, ".early_valid"}, 64'(out_valid), 64'd0);
        check({name, ".busy"}, 64'(busy), 64'd1);
        tick();
        expect_out(name, 1'b1, exp, t);
        tick();
        check({name, ".once"}, 64'(out_valid), 64'd0);
        check({name, ".hold"}, 64'(out_result), 64'(exp));
        check({name, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        rst_n = 1'b1;
        expect_out("reset", 1'b0, 32'h0, 5'd0);
        check("reset.busy", 64'(busy), 64'd0);

        run_one("mul_7xneg3", 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);
`ifdef MUL_HIGH_EN
        run_one("mulh_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_one("mulhu_max",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run_one("mulhsu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
`else
        run_one("mulh_low",   2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h0000_0000);
        run_one("op11_low",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
        run_one("op10_low",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001);
`endif

        // Back-to-back ops with a two-cycle stall after the second
        drive(1'b1, 2'b00, 32'd3, 32'd5, 5'd1);
        tick();
        drive(1'b1, 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd2);
        tick();
        expect_out("b2b.a", 1'b1, 32'd15, 5'd1);
        drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd2, 5'd3);
        stall = 1'b1;
        tick();
        expect_out("b2b.stall1", 1'b1, 32'd15, 5'd1);
        tick();
        expect_out("b2b.stall2", 1'b1, 32'd15, 5'd1);
        check("b2b.stall_busy", 64'(busy), 64'd1);
        stall = 1'b0;
        tick();
        expect_out("b2b.b", 1'b1, 32'h0, 5'd2);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        expect_out("b2b.c", 1'b1, 32'hFFFF_FFFE, 5'd3);
        tick();
        expect_out("b2b.drain", 1'b0, 32'hFFFF_FFFE, 5'd3);
        check("b2b.idle", 64'(busy), 64'd0);

        // Flush with stall and a new op on the same edge kills everything
        drive(1'b1, 2'b00, 32'd6, 32'd7, 5'd4);
        tick();
        drive(1'b1, 2'b00, 32'd10, 32'd10, 5'd5);
        tick();
        expect_out("flush.pre", 1'b1, 32'd42, 5'd4);
        drive(1'b1, 2'b00, 32'd11, 32'd11, 5'd6);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check("flush.valid", 64'(out_valid), 64'd0);
            check("flush.busy", 64'(busy), 64'd0);
            tick();
        end
        check("flush.hold", 64'(out_result), 64'd42);

        // Reset with one op in flight
        drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd7);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_out("rst_inflight", 1'b0, 32'h0, 5'd0);
        check("rst_inflight.busy", 64'(busy), 64'd0);
        tick();
        check("rst_inflight.aborted", 64'(out_valid), 64'd0);

        run_one("post_reset", 2'b00, 32'd12, 32'd12, 5'd31, 32'd144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
